key_event_ctrl: RTL

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl_pkg.sv | 21 ++
 rtl/key_event_ctrl_fsm.sv | 69 ++++++
 rtl/key_event_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/key_event_ctrl_pkg.sv
// Shared types and PS/2 scan-code constants for the key event controller.
package key_event_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2
  } key_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NONE   = 8'h00;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/key_event_ctrl_fsm.sv
// Byte fetch sequencer: pops one FIFO byte per IDLE->POP->DECODE pass and
// accumulates E0/F0 prefix flags until a final scan code is decoded.
module key_fsm
  import key_event_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ready,
  input  logic [7:0] i_data,
  output logic       o_nextdata_n,
  output key_state_e o_state,
  output logic [7:0] o_byte,
  output logic       o_ext_pending,
  output logic       o_brk_pending
);

  key_state_e r_state;
  key_state_e w_next_state;
  logic [7:0] r_byte;
  logic       r_ext_pending;
  logic       r_brk_pending;
  logic       w_nextdata_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_byte        <= SC_NONE;
      r_ext_pending <= 1'b0;
      r_brk_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && i_ready) begin
        r_byte <= i_data;
      end
      // Prefix flags persist until a final code consumes them.
      if (r_state == ST_DECODE) begin
        if (r_byte == SC_EXT) begin
          r_ext_pending <= 1'b1;
        end else if (r_byte == SC_BRK) begin
          r_brk_pending <= 1'b1;
        end else begin
          r_ext_pending <= 1'b0;
          r_brk_pending <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_nextdata_n = 1'b1;
    case (r_state)
      ST_IDLE:   if (i_ready) w_next_state = ST_POP;
      ST_POP: begin
        w_nextdata_n = 1'b0;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  assign o_nextdata_n  = w_nextdata_n;
  assign o_state       = r_state;
  assign o_byte        = r_byte;
  assign o_ext_pending = r_ext_pending;
  assign o_brk_pending = r_brk_pending;

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 key event controller: turns scan-code bytes into key events and
// tracks held key, shift, caps-lock, press count, conflict and overflow.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic [7:0]       held_code,
  output logic             shift_held,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_count,
  output logic             conflict,
  output logic             err
);

  key_state_e       w_state;
  logic [7:0]       w_byte;
  logic             w_ext_pending;
  logic             w_brk_pending;
  logic             w_event;
  logic             w_is_shift;
  logic             w_new_press;

  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_key_release;
  logic [7:0]       r_held_code;
  logic             r_lshift;
  logic             r_rshift;
  logic             r_caps_on;
  logic [CNT_W-1:0] r_press_count;
  logic             r_conflict;
  logic             r_err;

  key_fsm u_fsm (
    .i_clk         (clk),
    .i_rst_n       (clrn),
    .i_ready       (ready),
    .i_data        (data),
    .o_nextdata_n  (nextdata_n),
    .o_state       (w_state),
    .o_byte        (w_byte),
    .o_ext_pending (w_ext_pending),
    .o_brk_pending (w_brk_pending)
  );

  assign w_event     = (w_state == ST_DECODE) && !is_prefix(w_byte);
  assign w_is_shift  = !w_ext_pending && ((w_byte == SC_LSHIFT) || (w_byte == SC_RSHIFT));
  // A press counts as new unless it repeats the currently held key.
  assign w_new_press = !w_is_shift && !w_brk_pending &&
                       ((r_held_code == SC_NONE) || (w_byte != r_held_code));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key_valid   <= 1'b0;
      r_key_code    <= SC_NONE;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
      r_held_code   <= SC_NONE;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps_on     <= 1'b0;
      r_press_count <= '0;
      r_conflict    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_key_valid <= w_event;
      if (overflow) begin
        r_err <= 1'b1;
      end
      if (w_event) begin
        r_key_code    <= w_byte;
        r_key_ext     <= w_ext_pending;
        r_key_release <= w_brk_pending;
        if (w_is_shift) begin
          if (w_byte == SC_LSHIFT) r_lshift <= !w_brk_pending;
          else                     r_rshift <= !w_brk_pending;
        end else if (w_brk_pending) begin
          if (w_byte == r_held_code) begin
            r_held_code <= SC_NONE;
            r_conflict  <= 1'b0;
          end
        end else if (w_new_press) begin
          r_press_count <= r_press_count + CNT_W'(1);
          if (r_held_code == SC_NONE) r_held_code <= w_byte;
          else                        r_conflict  <= 1'b1;
          if (w_byte == SC_CAPS) r_caps_on <= !r_caps_on;
        end
      end
    end
  end

  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_release = r_key_release;
  assign held_code   = r_held_code;
  assign shift_held  = r_lshift | r_rshift;
  assign caps_on     = r_caps_on;
  assign press_count = r_press_count;
  assign conflict    = r_conflict;
  assign err         = r_err;

endmodule
